// File: rtl/view_scroller_if.sv
// view_scroller_if: game-side bundle between the doodle physics and the view scroller.
// Optional score signal present only with VIEW_SCROLLER_SCORE_EN.
`default_nettype none

interface view_scroller_if;
  logic        frameTick;
  logic [31:0] doodleY;
  logic [31:0] minY;
  logic        newView;
  logic        scrolling;
  logic        gameOver;
`ifdef VIEW_SCROLLER_SCORE_EN
  logic [31:0] score;
`endif

  modport master (
    output frameTick,
    output doodleY,
    input  minY,
    input  newView,
    input  scrolling,
`ifdef VIEW_SCROLLER_SCORE_EN
    input  score,
`endif
    input  gameOver
  );

  modport slave (
    input  frameTick,
    input  doodleY,
    output minY,
    output newView,
    output scrolling,
`ifdef VIEW_SCROLLER_SCORE_EN
    output score,
`endif
    output gameOver
  );
endinterface

`default_nettype wire

// File: rtl/view_scroller.sv
// ============================================================================
// Module   : view_scroller
// Purpose  : Moves the view bottom (minY) up in bounded steps as the doodle
//            climbs; declares game over when the doodle falls below the view.
// Options  : VIEW_SCROLLER_SCORE_EN adds a saturating scroll-step score.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module view_scroller #(
  parameter int SCREEN_HEIGHT = 700,
  parameter int SCROLL_MARGIN = 350,
  parameter int SCROLL_STEP   = 5
) (
  input  wire              clk,
  input  wire              reset,
  view_scroller_if.slave   bus
);

  localparam logic [31:0] c_margin = 32'(SCROLL_MARGIN);
  localparam logic [31:0] c_step   = 32'(SCROLL_STEP);

  generate
    if (SCROLL_MARGIN >= SCREEN_HEIGHT || SCROLL_STEP < 1) begin : g_param_check
      $error("view_scroller: margin must lie inside the screen and step must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCROLL = 2'd1,
    DEAD   = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] minY_q;
  logic [31:0] target_q;
  logic        newView_q;
  logic        scrolling_q;
  logic        gameOver_q;

  logic        w_below;
  logic        w_over_margin;
  logic        w_retarget;
  logic [31:0] w_target_eff;
  logic [31:0] w_gap;
  logic [31:0] w_step;
  logic [31:0] w_minY_d;
  logic        w_done;

  always_comb begin
    w_below       = bus.doodleY < minY_q;
    // Only evaluated as a subtraction when doodleY >= minY, so it never wraps.
    w_over_margin = !w_below && ((bus.doodleY - minY_q) > c_margin);
    // target + margin cannot overflow because target was derived as doodleY - margin.
    w_retarget    = bus.frameTick && (bus.doodleY > (target_q + c_margin));
    w_target_eff  = w_retarget ? (bus.doodleY - c_margin) : target_q;
    w_gap         = w_target_eff - minY_q;
    w_step        = (w_gap > c_step) ? c_step : w_gap;
    w_minY_d      = minY_q + w_step;
    w_done        = (w_minY_d == w_target_eff);
  end

`ifdef VIEW_SCROLLER_SCORE_EN
  logic [31:0] score_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q <= 32'd0;
    end else if (state_q == SCROLL && w_step != 32'd0 && score_q != 32'hFFFF_FFFF) begin
      score_q <= score_q + 32'd1;
    end
  end
  assign bus.score = score_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      minY_q      <= 32'd0;
      target_q    <= 32'd0;
      newView_q   <= 1'b0;
      scrolling_q <= 1'b0;
      gameOver_q  <= 1'b0;
    end else begin
      newView_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.frameTick) begin
            if (w_below) begin
              state_q    <= DEAD;
              gameOver_q <= 1'b1;
            end else if (w_over_margin) begin
              target_q    <= bus.doodleY - c_margin;
              state_q     <= SCROLL;
              scrolling_q <= 1'b1;
            end
          end
        end
        SCROLL: begin
          target_q <= w_target_eff;
          minY_q   <= w_minY_d;
          if (w_done) begin
            state_q     <= IDLE;
            scrolling_q <= 1'b0;
            newView_q   <= 1'b1;
          end
        end
        DEAD: begin
          state_q <= DEAD;
        end
        default: begin
          state_q     <= IDLE;
          scrolling_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.minY      = minY_q;
  assign bus.newView   = newView_q;
  assign bus.scrolling = scrolling_q;
  assign bus.gameOver  = gameOver_q;

endmodule

`default_nettype wire

// File: tb/tb_view_scroller.sv
// tb_view_scroller: directed vector table plus a hand-written async-reset sequence.
`default_nettype none

module tb_view_scroller;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  view_scroller_if bus();

  view_scroller #(
    .SCREEN_HEIGHT(700),
    .SCROLL_MARGIN(350),
    .SCROLL_STEP  (5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ft;
    logic [31:0] y;
    logic [31:0] e_miny;
    logic        e_nv;
    logic        e_sc;
    logic        e_go;
    logic [31:0] e_score;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rst, logic ft, logic [31:0] y, logic [31:0] miny,
                              logic nv, logic sc, logic go, logic [31:0] score);
    vec_t v;
    v.rst = rst; v.ft = ft; v.y = y; v.e_miny = miny;
    v.e_nv = nv; v.e_sc = sc; v.e_go = go; v.e_score = score;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] miny, input logic nv,
                               input logic sc, input logic go, input logic [31:0] score);
    check({tag, ".minY"},      bus.minY,      miny);
    check({tag, ".newView"},   32'(bus.newView),   32'(nv));
    check({tag, ".scrolling"}, 32'(bus.scrolling), 32'(sc));
    check({tag, ".gameOver"},  32'(bus.gameOver),  32'(go));
`ifdef VIEW_SCROLLER_SCORE_EN
    check({tag, ".score"},     bus.score,     score);
`else
    if (score != score) checks++;
`endif
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    reset         = 1'b1;
    bus.frameTick = 1'b0;
    bus.doodleY   = 32'd0;

    //              rst ft  y     minY nv sc go score
    vq.push_back(mk(0, 0,    0,    0, 0, 0, 0, 0));   // 0 idle after reset
    vq.push_back(mk(0, 1,  360,    0, 0, 1, 0, 0));   // 1 scroll starts, target 10
    vq.push_back(mk(0, 0,    0,    5, 0, 1, 0, 1));   // 2
    vq.push_back(mk(0, 0,    0,   10, 1, 0, 0, 2));   // 3 done, pulse
    vq.push_back(mk(0, 0,    0,   10, 0, 0, 0, 2));   // 4 pulse ends
    vq.push_back(mk(0, 1,  360,   10, 0, 0, 0, 2));   // 5 gap exactly margin: no scroll
    vq.push_back(mk(0, 1,   10,   10, 0, 0, 0, 2));   // 6 doodleY == minY: no death
    vq.push_back(mk(0, 1,  363,   10, 0, 1, 0, 2));   // 7 target 13
    vq.push_back(mk(0, 0,    0,   13, 1, 0, 0, 3));   // 8 single short step
    vq.push_back(mk(0, 0,    0,   13, 0, 0, 0, 3));   // 9
    vq.push_back(mk(0, 1,  373,   13, 0, 1, 0, 3));   // 10 target 23
    vq.push_back(mk(0, 0,    0,   18, 0, 1, 0, 4));   // 11
    vq.push_back(mk(0, 1,  393,   23, 0, 1, 0, 5));   // 12 retarget to 43, no pulse at 23
    vq.push_back(mk(0, 1,  380,   28, 0, 1, 0, 6));   // 13 lower target ignored
    vq.push_back(mk(0, 1,    5,   33, 0, 1, 0, 7));   // 14 fall ignored in SCROLL
    vq.push_back(mk(0, 0,    0,   38, 0, 1, 0, 8));   // 15
    vq.push_back(mk(0, 0,    0,   43, 1, 0, 0, 9));   // 16 single pulse at 43
    vq.push_back(mk(0, 0,    0,   43, 0, 0, 0, 9));   // 17
    vq.push_back(mk(0, 1,   42,   43, 0, 0, 1, 9));   // 18 death
    vq.push_back(mk(0, 1, 1000,   43, 0, 0, 1, 9));   // 19 DEAD holds
    vq.push_back(mk(0, 1, 2000,   43, 0, 0, 1, 9));   // 20
    vq.push_back(mk(1, 0,    0,    0, 0, 0, 0, 0));   // 21 reset clears all
    vq.push_back(mk(0, 1,  360,    0, 0, 1, 0, 0));   // 22 first tick after reset honoured
    vq.push_back(mk(0, 0,    0,    5, 0, 1, 0, 1));   // 23 mid-scroll at minY=5

    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset_state", 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);

    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      reset         = vq[i].rst;
      bus.frameTick = vq[i].ft;
      bus.doodleY   = vq[i].y;
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), vq[i].e_miny, vq[i].e_nv,
                    vq[i].e_sc, vq[i].e_go, vq[i].e_score);
    end

    // Asynchronous reset mid-scroll: effect must be visible before the next edge.
    @(negedge clk);
    bus.frameTick = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check_outputs("async_reset", 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    @(posedge clk);
    #1;
    check_outputs("reset_hold", 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);

    @(negedge clk);
    reset         = 1'b0;
    bus.frameTick = 1'b1;
    bus.doodleY   = 32'd200;
    @(posedge clk);
    #1;
    check_outputs("post_reset_200", 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    bus.frameTick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("post_reset_idle", 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
